// File: rtl/apb_pkg.sv
// Shared types and constants for the matrix-multiplier APB requester.
// Register map and state encoding used by the master port and its users.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_t;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 16;

  localparam logic [2:0] REG_A_ADDR = 3'd0;
  localparam logic [2:0] REG_B_ADDR = 3'd1;
  localparam logic [2:0] REG_C_ADDR = 3'd2;
  localparam logic [2:0] REG_M      = 3'd3;
  localparam logic [2:0] REG_N      = 3'd4;
  localparam logic [2:0] REG_P      = 3'd5;
  localparam logic [2:0] REG_STATE  = 3'd6;

  localparam int STATE_START_BIT = 0;
  localparam int STATE_END_BIT   = 1;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter for the APB requester.
// Flags expiry once TIMEOUT-1 stalled cycles have been counted.
module apb_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_port.sv
// Single-transfer APB requester: one command in, one SETUP/ACCESS
// transfer on the bus, one response out (with timeout abort).
module apb_master_port
  import apb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  apb_state_t state;
  apb_state_t state_nxt;

  logic expired;
  logic accept;
  logic done;

  assign cmd_ready = (state == IDLE);
  assign psel      = (state == SETUP) || (state == ACCESS);
  assign penable   = (state == ACCESS);
  assign rsp_valid = (state == RESP);

  assign accept = cmd_valid && cmd_ready;
  // pready on the expiry edge still counts as a normal completion
  assign done   = (state == ACCESS) && (pready || expired);

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (pclk),
    .rst_n   (preset_n),
    .clear   (state != ACCESS),
    .enable  ((state == ACCESS) && !pready),
    .expired (expired)
  );

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (accept) state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: if (done) state_nxt = RESP;
      RESP:   if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (accept) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_wdata;
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (done) begin
      rsp_err   <= !pready;
      rsp_rdata <= (pready && !pwrite) ? prdata : '0;
    end
  end

endmodule

// File: tb/tb_apb_master_port.sv
// Directed and randomized checks of apb_master_port against a
// transaction-level register-file model.
module tb_apb_master_port;

  localparam int T = 15;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [2:0]  cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [2:0]  paddr;
  logic [15:0] pwdata;
  logic        pready = 1'b0;
  logic [15:0] prdata = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] slave_mem [8];
  logic [15:0] model_mem [8];

  apb_master_port #(
    .ADDR_W  (3),
    .DATA_W  (16),
    .TIMEOUT (T)
  ) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic xfer(input bit          w,
                      input logic [2:0]  a,
                      input logic [15:0] d,
                      input int          waits,
                      input int          rdelay,
                      input bit          keep);
    int n;
    int exp_n;
    bit exp_err;
    logic [15:0] exp_rd;
    exp_err = (waits >= T);
    exp_n   = exp_err ? T : waits + 1;
    exp_rd  = (w || exp_err) ? 16'h0 : model_mem[a];
    if (w && !exp_err) model_mem[a] = d;

    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    step();
    if (keep) begin
      cmd_write = !w;
      cmd_addr  = a + 3'd5;
      cmd_wdata = ~d;
    end else begin
      cmd_valid = 1'b0;
    end
    chk("setup_psel", 32'(psel), 32'd1);
    chk("setup_penable", 32'(penable), 32'd0);
    chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("setup_paddr", 32'(paddr), 32'(a));
    chk("setup_pwrite", 32'(pwrite), 32'(w));
    if (w) chk("setup_pwdata", 32'(pwdata), 32'(d));
    step();

    n = 0;
    while (psel === 1'b1 && n < T + 3) begin
      chk("access_penable", 32'(penable), 32'd1);
      chk("access_paddr", 32'(paddr), 32'(a));
      chk("access_pwrite", 32'(pwrite), 32'(w));
      if (w) chk("access_pwdata", 32'(pwdata), 32'(d));
      chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
      if (keep) chk("access_cmd_ready", 32'(cmd_ready), 32'd0);
      pready = (n >= waits);
      prdata = pready ? slave_mem[paddr] : 16'($urandom);
      if (pready && pwrite) slave_mem[paddr] = pwdata;
      step();
      n++;
    end
    pready = 1'b0;
    prdata = 16'($urandom);
    chk("access_cycles", 32'(n), 32'(exp_n));
    chk("resp_penable", 32'(penable), 32'd0);

    for (int i = 0; i <= rdelay; i++) begin
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
      chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("resp_psel", 32'(psel), 32'd0);
      rsp_ready = (i == rdelay);
      step();
    end
    rsp_ready = 1'b0;
    chk("rsp_released", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int wtab [8];
    wtab = '{0, 0, 1, 2, 3, 14, 15, 20};
    for (int i = 0; i < 8; i++) begin
      slave_mem[i] = 16'($urandom);
      model_mem[i] = slave_mem[i];
    end

    preset_n = 1'b0;
    step();
    step();
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", 32'(pwdata), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    preset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_psel", 32'(psel), 32'd0);
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    end

    xfer(1'b1, 3'd3, 16'h0004, 0, 0, 1'b0);
    model_mem[6] = 16'h0002;
    slave_mem[6] = 16'h0002;
    xfer(1'b0, 3'd6, 16'h0, 3, 0, 1'b0);
    xfer(1'b0, 3'd2, 16'h0, 100, 0, 1'b0);
    xfer(1'b0, 3'd6, 16'h0, T - 1, 1, 1'b0);
    xfer(1'b1, 3'd4, 16'h1234, 1, 5, 1'b1);
    xfer(1'b0, 3'd4, 16'h0, 0, 0, 1'b0);

    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 3'd5;
    cmd_wdata = 16'hbeef;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("abort_in_access", 32'(penable), 32'd1);
    preset_n = 1'b0;
    step();
    preset_n = 1'b1;
    chk("abort_psel", 32'(psel), 32'd0);
    chk("abort_penable", 32'(penable), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_no_psel", 32'(psel), 32'd0);
    end
    xfer(1'b0, 3'd5, 16'h0, 0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      xfer(1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)),
           16'($urandom),
           wtab[$urandom_range(0, 7)],
           int'($urandom_range(0, 3)),
           1'b0);
    end
    for (int a = 0; a < 8; a++) begin
      xfer(1'b0, 3'(a), 16'h0, 0, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_master_port.md
# apb_master_port

Command-driven APB requester that issues single read/write transfers to the matrix-multiplier register file (A/B/C base addresses, M/N/P, state register). It sits between a host-side controller (test sequencer or CPU bridge) and the register block's APB port. It converts one valid/ready command into one APB SETUP/ACCESS transfer, waits for `pready` with a bounded timeout, and returns read data and status on a valid/ready response channel.

## Interface
Parameters:
- `ADDR_W`, 3: APB address width; the register file has 8 word slots.
- `DATA_W`, 16: APB data width.
- `TIMEOUT`, 15: maximum ACCESS cycles without `pready` before abort; must be ≥1.

Ports:
- `pclk` in 1: clock.
- `preset_n` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on the edge where both are high.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: register address.
- `cmd_wdata` in DATA_W: write data; ignored on reads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed on the edge where both are high.
- `rsp_rdata` out DATA_W: read data; 0 for writes and timeouts.
- `rsp_err` out 1: transfer timed out.
- `psel` out 1: APB select.
- `penable` out 1: APB enable; driven by this block.
- `pwrite` out 1: APB direction.
- `paddr` out ADDR_W: APB address.
- `pwdata` out DATA_W: APB write data.
- `pready` in 1: completer ready.
- `prdata` in DATA_W: completer read data.

## Operation
- FSM with four states:
  - IDLE → SETUP on `cmd_valid & cmd_ready`.
  - SETUP → ACCESS unconditionally.
  - ACCESS → RESP on `pready`, or on timeout.
  - RESP → IDLE on `rsp_ready`.
- `cmd_ready` = (state == IDLE). It is combinational from state only and never depends on `cmd_valid`.
- On accept: capture `cmd_write`, `cmd_addr`, `cmd_wdata` into registers. `paddr`, `pwrite`, `pwdata` are driven from these registers and stay stable from SETUP through the end of ACCESS.
- SETUP: `psel`=1, `penable`=0. ACCESS: `psel`=1, `penable`=1.
- ACCESS completion:
  - On the edge with `pready`=1: for reads, latch `prdata` into `rsp_rdata`; for writes, load 0; set `rsp_err`=0.
  - Timeout: wait counter clears on entering ACCESS and increments each ACCESS cycle with `pready`=0. When it reaches TIMEOUT−1 and `pready` is still 0, leave ACCESS with `rsp_err`=1 and `rsp_rdata`=0.
  - If `pready`=1 on that same edge, it is a normal completion; success wins over timeout.
- RESP: `rsp_valid`=1. `rsp_rdata` and `rsp_err` are held until `rsp_ready`. Bus signals are idle.
- Out of ACCESS, `psel`, `penable` = 0. `paddr`, `pwdata`, `pwrite` retain their last values and carry no meaning.
- Counter width is $clog2(TIMEOUT+1). No wrap is possible because exit is forced at the limit.

## Timing
- Reset (synchronous, `preset_n`=0 at an edge) forces IDLE from any state, including mid-ACCESS. The abandoned transfer produces no response.
- Reset values: `psel`, `penable`, `pwrite` = 0; `paddr`, `pwdata` = 0; `rsp_valid`, `rsp_err` = 0; `rsp_rdata` = 0; `cmd_ready` = 1 after reset.
- Accept at edge E0. SETUP is visible after E0. ACCESS is visible after E1.
- Zero-wait-state completion at E2; `rsp_valid` is high after E2.
- Each wait state adds one cycle.
- Minimum command-to-command period is 4 cycles when `rsp_ready` is held high: IDLE, SETUP, ACCESS, RESP.
- `cmd_valid` held during SETUP/ACCESS/RESP is not accepted; `cmd_ready`=0 there.
- `rsp_ready` outside RESP has no effect.

## Structure
- Package `apb_pkg`:
  - `apb_state_t` enum {IDLE, SETUP, ACCESS, RESP};
  - default width constants (ADDR_W=3, DATA_W=16);
  - register address constants:
    - `REG_A_ADDR`=0, `REG_B_ADDR`=1, `REG_C_ADDR`=2;
    - `REG_M`=3, `REG_N`=4, `REG_P`=5;
    - `REG_STATE`=6;
  - `STATE_START_BIT`=0, `STATE_END_BIT`=1.
- One sub-module, `apb_wait_timer`: clear/enable inputs, `expired` output, parameterised by TIMEOUT. Everything else lives in a single FSM module.

## Test plan
- Reset then idle: outputs match the reset values; `cmd_ready`=1; `psel`=0 for 10 cycles with `cmd_valid`=0.
- Write addr 3, data 0x0004, `pready` tied 1:
  - `psel` high 2 cycles;
  - `penable` high in the 2nd cycle only;
  - `paddr`=3, `pwdata`=0x0004, `pwrite`=1 stable throughout;
  - `rsp_valid` after 2 edges with `rsp_err`=0, `rsp_rdata`=0.
- Read addr 6, `pready` low 3 ACCESS cycles then high, `prdata`=0x0002:
  - ACCESS lasts 4 cycles;
  - `rsp_rdata`=0x0002, `rsp_err`=0.
- Timeout with TIMEOUT=15, `pready` stuck 0:
  - exactly 15 ACCESS cycles, then `psel`=0;
  - `rsp_err`=1, `rsp_rdata`=0.
  - Variant with `pready` rising on the 15th cycle: `rsp_err`=0.
- Backpressure: `rsp_ready`=0 for 5 cycles while a second command is held valid:
  - `rsp_valid` and data held;
  - `cmd_ready`=0;
  - the second command is accepted on the cycle after the response handshake.
- Reset mid-ACCESS: `preset_n`=0 for one edge with `pready`=0:
  - next cycle `psel`=`penable`=0, `rsp_valid`=0, `cmd_ready`=1;
  - no response is ever produced for the aborted command.
